// File: rtl/icache_prefetch_buf.sv
// Next-line prefetch buffer between the instruction cache miss port and memory.
// Misses are served from a one-entry buffer on a match, otherwise from memory.
//
// state      | meaning
// S_IDLE     | waiting for a miss; buffer may hold the next line
// S_HIT_RESP | one-cycle response from buffer or forwarded prefetch data
// S_D_REQ    | demand request to memory, held until granted
// S_D_WAIT   | waiting for demand read data
// S_D_RESP   | one-cycle response with registered demand data
// S_PF_REQ   | prefetch request for the next sequential word
// S_PF_WAIT  | prefetch in flight; never cancelled
module icache_prefetch_buf #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter bit PF_ENABLE  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cache_req,
  input  logic [ADDR_WIDTH-1:0] cache_addr,
  output logic [DATA_WIDTH-1:0] cache_data,
  output logic                  cache_ready,
  input  logic                  flush,
  output logic                  dram_req,
  output logic [ADDR_WIDTH-1:0] dram_addr,
  input  logic                  dram_gnt,
  input  logic                  dram_rvalid,
  input  logic [DATA_WIDTH-1:0] dram_rdata,
  output logic                  pf_hit,
  output logic                  pf_issue
);

  typedef enum logic [2:0] {
    S_IDLE, S_HIT_RESP, S_D_REQ, S_D_WAIT, S_D_RESP, S_PF_REQ, S_PF_WAIT
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] WORD_STEP = ADDR_WIDTH'(4);

  state_t                  state_q, state_d;
  logic                    buf_valid_q, buf_valid_d;
  logic [ADDR_WIDTH-1:0]   buf_addr_q, buf_addr_d;
  logic [DATA_WIDTH-1:0]   buf_data_q, buf_data_d;
  logic [ADDR_WIDTH-1:0]   pf_addr_q, pf_addr_d;
  logic [ADDR_WIDTH-1:0]   req_addr_q, req_addr_d;
  logic [DATA_WIDTH-1:0]   resp_data_q, resp_data_d;
  logic                    flush_seen_q, flush_seen_d;
  logic                    pf_issue_q, pf_issue_d;

  logic [ADDR_WIDTH-1:0]   cache_addr_al;
  state_t                  resp_next;
  logic                    unused_addr_bits;

  assign cache_addr_al    = {cache_addr[ADDR_WIDTH-1:2], 2'b00};
  assign unused_addr_bits = ^cache_addr[1:0];
  assign resp_next        = PF_ENABLE ? S_PF_REQ : S_IDLE;

  always_comb begin
    state_d      = state_q;
    buf_valid_d  = buf_valid_q;
    buf_addr_d   = buf_addr_q;
    buf_data_d   = buf_data_q;
    pf_addr_d    = pf_addr_q;
    req_addr_d   = req_addr_q;
    resp_data_d  = resp_data_q;
    flush_seen_d = flush_seen_q;
    pf_issue_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cache_req) begin
          if (buf_valid_q && (buf_addr_q == cache_addr_al) && !flush) begin
            state_d     = S_HIT_RESP;
            resp_data_d = buf_data_q;
            pf_addr_d   = buf_addr_q + WORD_STEP;
          end else begin
            state_d     = S_D_REQ;
            req_addr_d  = cache_addr_al;
            buf_valid_d = 1'b0;
          end
        end
      end
      S_HIT_RESP: begin
        buf_valid_d = 1'b0;
        state_d     = resp_next;
      end
      S_D_REQ: begin
        if (dram_gnt) state_d = S_D_WAIT;
      end
      S_D_WAIT: begin
        if (dram_rvalid) begin
          resp_data_d = dram_rdata;
          pf_addr_d   = req_addr_q + WORD_STEP;
          state_d     = S_D_RESP;
        end
      end
      S_D_RESP: begin
        state_d = resp_next;
      end
      S_PF_REQ: begin
        if (dram_gnt) begin
          pf_issue_d   = 1'b1;
          flush_seen_d = flush;
          state_d      = S_PF_WAIT;
        end
      end
      S_PF_WAIT: begin
        if (flush) flush_seen_d = 1'b1;
        if (dram_rvalid) begin
          flush_seen_d = 1'b0;
          if (flush || flush_seen_q) begin
            state_d = S_IDLE;
          end else if (cache_req && (cache_addr_al == pf_addr_q)) begin
            // Demand miss caught up with the prefetch: forward, skip the buffer.
            resp_data_d = dram_rdata;
            pf_addr_d   = pf_addr_q + WORD_STEP;
            state_d     = S_HIT_RESP;
          end else begin
            buf_valid_d = 1'b1;
            buf_addr_d  = pf_addr_q;
            buf_data_d  = dram_rdata;
            state_d     = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (flush) buf_valid_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      buf_valid_q  <= 1'b0;
      buf_addr_q   <= '0;
      buf_data_q   <= '0;
      pf_addr_q    <= '0;
      req_addr_q   <= '0;
      resp_data_q  <= '0;
      flush_seen_q <= 1'b0;
      pf_issue_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      buf_valid_q  <= buf_valid_d;
      buf_addr_q   <= buf_addr_d;
      buf_data_q   <= buf_data_d;
      pf_addr_q    <= pf_addr_d;
      req_addr_q   <= req_addr_d;
      resp_data_q  <= resp_data_d;
      flush_seen_q <= flush_seen_d;
      pf_issue_q   <= pf_issue_d;
    end
  end

  always_comb begin
    dram_addr = '0;
    if (state_q == S_D_REQ)  dram_addr = req_addr_q;
    if (state_q == S_PF_REQ) dram_addr = pf_addr_q;
  end

  assign dram_req    = (state_q == S_D_REQ) || (state_q == S_PF_REQ);
  assign cache_ready = (state_q == S_HIT_RESP) || (state_q == S_D_RESP);
  assign cache_data  = resp_data_q;
  assign pf_hit      = (state_q == S_HIT_RESP);
  assign pf_issue    = pf_issue_q;

endmodule

// File: tb/tb_icache_prefetch_buf.sv
// Bench for icache_prefetch_buf: directed scenarios plus randomized misses
// checked against a next-line model and a randomly timed memory.
module tb_icache_prefetch_buf;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        cache_req, flush, cache_ready, dram_req, dram_gnt, dram_rvalid, pf_hit, pf_issue;
  logic [31:0] cache_addr, cache_data, dram_addr, dram_rdata;

  logic        c0_req, c0_flush, c0_ready, d0_req, d0_gnt, d0_rvalid, c0_pf_hit, d0_pf_issue;
  logic [31:0] c0_addr, c0_data, d0_addr, d0_rdata;

  icache_prefetch_buf #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .PF_ENABLE(1'b1)) dut (
    .clk(clk), .rst(rst), .cache_req(cache_req), .cache_addr(cache_addr),
    .cache_data(cache_data), .cache_ready(cache_ready), .flush(flush),
    .dram_req(dram_req), .dram_addr(dram_addr), .dram_gnt(dram_gnt),
    .dram_rvalid(dram_rvalid), .dram_rdata(dram_rdata),
    .pf_hit(pf_hit), .pf_issue(pf_issue)
  );

  icache_prefetch_buf #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .PF_ENABLE(1'b0)) dut0 (
    .clk(clk), .rst(rst), .cache_req(c0_req), .cache_addr(c0_addr),
    .cache_data(c0_data), .cache_ready(c0_ready), .flush(c0_flush),
    .dram_req(d0_req), .dram_addr(d0_addr), .dram_gnt(d0_gnt),
    .dram_rvalid(d0_rvalid), .dram_rdata(d0_rdata),
    .pf_hit(c0_pf_hit), .pf_issue(d0_pf_issue)
  );

  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;

  logic [31:0] mem_ov [bit [31:0]];

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (mem_ov.exists(a)) return mem_ov[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory for the prefetching instance: random grant delay and read latency.
  int          gmax = 0, lmin = 2, lmax = 2;
  int          gwait = 0, wait_cnt = 0, pend_cnt = 0, gnt_count = 0;
  bit          pend = 1'b0;
  logic [31:0] pend_addr = '0, last_gnt_addr = '0;
  logic [31:0] pfq [$];

  initial begin
    dram_gnt = 1'b0; dram_rvalid = 1'b0; dram_rdata = '0;
    forever begin
      @(posedge clk); #1;
      dram_gnt = 1'b0; dram_rvalid = 1'b0;
      if (pf_issue) pfq.push_back(last_gnt_addr);
      if (pend) begin
        check("one_outstanding", {31'b0, dram_req}, 32'd0);
        if (pend_cnt == 0) begin
          dram_rvalid = 1'b1; dram_rdata = mem_val(pend_addr); pend = 1'b0;
        end else pend_cnt--;
      end else if (dram_req) begin
        if (wait_cnt >= gwait) begin
          check("dram_addr_align", {30'b0, dram_addr[1:0]}, 32'd0);
          dram_gnt = 1'b1; pend = 1'b1; pend_addr = dram_addr; last_gnt_addr = dram_addr;
          gnt_count++;
          pend_cnt = $urandom_range(lmax, lmin);
          wait_cnt = 0;
          gwait = $urandom_range(gmax, 0);
        end else wait_cnt++;
      end else if (wait_cnt != 0) begin
        check("dram_req_held", 32'd0, 32'd1);
        wait_cnt = 0;
      end
    end
  end

  task automatic serve(input logic [31:0] addr, input bit do_flush, output int lat,
                       output bit hit, output logic [31:0] data, output int ngnt,
                       output logic [31:0] gaddr);
    int g0;
    g0 = gnt_count;
    cache_req = 1'b1; cache_addr = addr; flush = do_flush;
    lat = 0; hit = 1'b0; data = '0;
    while (lat < 300) begin
      @(posedge clk); #1;
      flush = 1'b0;
      lat++;
      if (cache_ready) break;
    end
    if (cache_ready) begin
      hit = pf_hit; data = cache_data;
    end else check("ready_timeout", 32'd0, 32'd1);
    cache_req = 1'b0;
    ngnt = gnt_count - g0;
    gaddr = last_gnt_addr;
    @(posedge clk); #1;
    check("ready_single_cycle", {31'b0, cache_ready}, 32'd0);
  endtask

  task automatic wait_pf(input logic [31:0] exp);
    int n;
    n = 0;
    while (pfq.size() == 0 && n < 300) begin
      @(posedge clk); #1; n++;
    end
    if (pfq.size() == 0) check("pf_issue_timeout", 32'd0, 32'd1);
    else check("pf_addr", pfq.pop_front(), exp);
  endtask

  // Next-line model: a miss hits iff it asks for the word after the last one
  // served since reset and no flush came with it.
  bit          have_last = 1'b0;
  logic [31:0] last_al = '0;

  task automatic step(input logic [31:0] addr, input bit do_flush, output int lat);
    logic [31:0] al, data, gaddr;
    bit          exp_hit, hit;
    int          ngnt;
    al = {addr[31:2], 2'b00};
    exp_hit = have_last && (al == last_al + 32'd4) && !do_flush;
    serve(addr, do_flush, lat, hit, data, ngnt, gaddr);
    check("resp_data", data, mem_val(al));
    check("pf_hit", {31'b0, hit}, {31'b0, exp_hit});
    if (exp_hit) check("hit_no_demand", ngnt, 32'd0);
    else begin
      check("demand_count", ngnt, 32'd1);
      check("demand_addr", gaddr, al);
    end
    have_last = 1'b1;
    last_al = al;
    wait_pf(al + 32'd4);
  endtask

  task automatic serve0(input logic [31:0] addr, output logic [31:0] data, output bit hit,
                        output int ngnt, output int nextra);
    bit          p, done;
    int          cnt;
    logic [31:0] pa;
    p = 1'b0; done = 1'b0; cnt = 0; pa = '0;
    ngnt = 0; nextra = 0; hit = 1'b0; data = '0;
    c0_req = 1'b1; c0_addr = addr;
    for (int i = 0; i < 100 && !done; i++) begin
      @(posedge clk); #1;
      d0_gnt = 1'b0; d0_rvalid = 1'b0;
      if (d0_pf_issue) nextra++;
      if (c0_ready) begin
        done = 1'b1; data = c0_data; hit = c0_pf_hit; c0_req = 1'b0;
      end else if (p) begin
        if (cnt == 0) begin
          d0_rvalid = 1'b1; d0_rdata = mem_val(pa); p = 1'b0;
        end else cnt--;
      end else if (d0_req) begin
        d0_gnt = 1'b1; p = 1'b1; cnt = 1; pa = d0_addr; ngnt++;
      end
    end
    if (!done) check("ready0_timeout", 32'd0, 32'd1);
    repeat (15) begin
      @(posedge clk); #1;
      if (d0_req || d0_pf_issue) nextra++;
    end
  endtask

  initial begin
    int          lat, ngnt0, nextra0;
    bit          hit0, bad;
    logic [31:0] data0, a, base;

    cache_req = 1'b0; cache_addr = '0; flush = 1'b0;
    c0_req = 1'b0; c0_addr = '0; c0_flush = 1'b0;
    d0_gnt = 1'b0; d0_rvalid = 1'b0; d0_rdata = '0;
    mem_ov[32'h0000_0100] = 32'hDEAD_BEEF;
    mem_ov[32'h0000_0104] = 32'hCAFE_F00D;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cache_ready", {31'b0, cache_ready}, 32'd0);
    check("rst_dram_req", {31'b0, dram_req}, 32'd0);
    check("rst_pf_hit", {31'b0, pf_hit}, 32'd0);
    check("rst_pf_issue", {31'b0, pf_issue}, 32'd0);
    check("rst_dram_addr", dram_addr, 32'd0);
    check("rst_cache_data", cache_data, 32'd0);
    check("rst0_outputs", {28'b0, c0_ready, d0_req, c0_pf_hit, d0_pf_issue}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Miss with immediate grant, rvalid three cycles after grant.
    step(32'h0000_0100, 1'b0, lat);
    check("miss_latency", lat, 32'd5);
    repeat (8) @(posedge clk);
    #1;
    lmin = 5; lmax = 5;
    // Buffered hit, then a miss that catches the prefetch in flight.
    step(32'h0000_0104, 1'b0, lat);
    check("hit_latency", lat, 32'd1);
    step(32'h0000_0108, 1'b0, lat);
    // Non-matching miss while prefetch 0x10C is outstanding.
    step(32'h0000_0200, 1'b0, lat);

    lmin = 1; lmax = 1;
    step(32'h0000_02FC, 1'b0, lat);
    repeat (8) @(posedge clk);
    #1;
    step(32'h0000_0300, 1'b1, lat);

    step(32'hFFFF_FFFC, 1'b0, lat);
    step(32'h0000_0001, 1'b0, lat);

    // Reset in the middle of a demand miss; the late rvalid must be ignored.
    lmin = 6; lmax = 6;
    repeat (12) @(posedge clk);
    #1;
    cache_req = 1'b1; cache_addr = 32'h0000_0500;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1; cache_req = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_outputs", {30'b0, cache_ready, dram_req}, 32'd0);
    rst = 1'b0;
    pfq.delete();
    have_last = 1'b0;
    bad = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (cache_ready || dram_req || pf_issue) bad = 1'b1;
    end
    check("stray_rvalid_ignored", {31'b0, bad}, 32'd0);
    step(32'h0000_0504, 1'b0, lat);

    for (int i = 0; i < 40; i++) begin
      gmax = $urandom_range(3, 0); lmin = 0; lmax = 4;
      repeat ($urandom_range(6, 0)) @(posedge clk);
      #1;
      case ($urandom_range(9, 0))
        0, 1, 2, 3, 4: base = last_al + 32'd4;
        5, 6:          base = {22'b0, 8'($urandom_range(255, 0)), 2'b00};
        7:             base = 32'hFFFF_FFFC;
        default:       base = last_al;
      endcase
      a = base | 32'($urandom_range(3, 0));
      step(a, ($urandom_range(4, 0) == 0), lat);
    end

    // Pass-through instance: never prefetches, never hits.
    serve0(32'hFFFF_FFFC, data0, hit0, ngnt0, nextra0);
    check("pt_data", data0, mem_val(32'hFFFF_FFFC));
    check("pt_hit", {31'b0, hit0}, 32'd0);
    check("pt_gnt", ngnt0, 32'd1);
    check("pt_no_prefetch", nextra0, 32'd0);
    serve0(32'h0000_0000, data0, hit0, ngnt0, nextra0);
    check("pt_seq_data", data0, mem_val(32'h0000_0000));
    check("pt_seq_hit", {31'b0, hit0}, 32'd0);
    check("pt_seq_gnt", ngnt0, 32'd1);
    check("pt_seq_no_prefetch", nextra0, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
